// File: rtl/decode_ctrl_pipe.sv
// ID-stage control unit: decodes the IF/ID opcode into the ID/EX control register,
// inserts load-use bubbles, squashes on flush and flags unknown opcodes.
module decode_ctrl_pipe #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned PERF_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              valid_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              ALUSrc_o,
  output logic              ALUSigned_o,
  output logic              Branch_o,
  output logic              Jump_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [2:0]        ALU_op_o,
  output logic [1:0]        RegDst_o,
  output logic [1:0]        BranchType_o,
  output logic [1:0]        MemToReg_o,
  output logic              illegal_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int unsigned CntW = $clog2(STALL_CYCLES + 1);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       alu_src;
    logic       alu_signed;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] branch_type;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       unused_instr;

  assign op           = instr_i[31:26];
  assign rs           = instr_i[25:21];
  assign rt           = instr_i[20:16];
  assign unused_instr = ^instr_i[15:0];

  ctrl_t            ctrl_d, ctrl_q, dec;
  logic             illegal_d, illegal_q;
  logic [4:0]       ex_rt_d, ex_rt_q;
  logic [CntW-1:0]  cnt_d, cnt_q;
  logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q;
  logic             known, rt_src, hazard, stall;

  always_comb begin
    dec            = '0;
    dec.valid      = 1'b1;
    dec.alu_signed = 1'b1;
    known          = 1'b1;
    rt_src         = 1'b0;
    case (op)
      6'd0: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 2'd1;
        dec.alu_op    = 3'b010;
        rt_src        = 1'b1;
      end
      6'd2: dec.jump = 1'b1;
      6'd3: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.reg_dst    = 2'd2;
        dec.mem_to_reg = 2'd2;
      end
      6'd4, 6'd5, 6'd6, 6'd1: begin
        dec.branch = 1'b1;
        dec.alu_op = 3'b001;
        rt_src     = (op == 6'd4) || (op == 6'd5);
        case (op)
          6'd5:    dec.branch_type = 2'd1;
          6'd6:    dec.branch_type = 2'd2;
          6'd1:    dec.branch_type = 2'd3;
          default: dec.branch_type = 2'd0;
        endcase
      end
      6'd8, 6'd9, 6'd13, 6'd15: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        case (op)
          6'd9:    begin dec.alu_op = 3'b011; dec.alu_signed = 1'b0; end
          6'd13:   begin dec.alu_op = 3'b100; dec.alu_signed = 1'b0; end
          6'd15:   dec.alu_op = 3'b101;
          default: dec.alu_op = 3'b000;
        endcase
      end
      6'd35: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 2'd1;
      end
      6'd43: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        rt_src        = 1'b1;
      end
      default: begin
        dec   = '0;
        known = 1'b0;
      end
    endcase
  end

  // Only a real load in ID/EX can cause a hazard; bubbles carry valid=0 and rt=0.
  always_comb begin
    hazard = (cnt_q == '0) && ctrl_q.valid && ctrl_q.mem_read && (ex_rt_q != 5'd0) &&
             valid_i && ((ex_rt_q == rs) || (rt_src && (ex_rt_q == rt)));
    stall  = hazard || (cnt_q != '0);
  end

  always_comb begin
    ctrl_d      = '0;
    illegal_d   = 1'b0;
    ex_rt_d     = 5'd0;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (stall) begin
      cnt_d = hazard ? CntW'(STALL_CYCLES - 1) : cnt_q - CntW'(1);
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end else if (valid_i) begin
      if (known) begin
        ctrl_d  = dec;
        ex_rt_d = rt;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      ex_rt_q     <= 5'd0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      ex_rt_q     <= ex_rt_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o      = stall;
  assign valid_o      = ctrl_q.valid;
  assign RegWrite_o   = ctrl_q.reg_write;
  assign ALUSrc_o     = ctrl_q.alu_src;
  assign ALUSigned_o  = ctrl_q.alu_signed;
  assign Branch_o     = ctrl_q.branch;
  assign Jump_o       = ctrl_q.jump;
  assign MemRead_o    = ctrl_q.mem_read;
  assign MemWrite_o   = ctrl_q.mem_write;
  assign ALU_op_o     = ctrl_q.alu_op;
  assign RegDst_o     = ctrl_q.reg_dst;
  assign BranchType_o = ctrl_q.branch_type;
  assign MemToReg_o   = ctrl_q.mem_to_reg;
  assign illegal_o    = illegal_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: one instance with one stall bubble per hazard,
// one with two, sharing the same stimulus.
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;

  logic        s1, v1, rw1, as1, sg1, br1, j1, mr1, mw1, il1;
  logic [2:0]  aop1;
  logic [1:0]  rd1, bt1, mtr1;
  logic [15:0] sc1;
  logic        s2, v2, rw2, as2, sg2, br2, j2, mr2, mw2, il2;
  logic [2:0]  aop2;
  logic [1:0]  rd2, bt2, mtr2;
  logic [15:0] sc2;
  logic [17:0] vec1, vec2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.STALL_CYCLES(1), .PERF_W(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr), .valid_i(valid), .flush_i(flush),
    .stall_o(s1), .valid_o(v1), .RegWrite_o(rw1), .ALUSrc_o(as1), .ALUSigned_o(sg1),
    .Branch_o(br1), .Jump_o(j1), .MemRead_o(mr1), .MemWrite_o(mw1), .ALU_op_o(aop1),
    .RegDst_o(rd1), .BranchType_o(bt1), .MemToReg_o(mtr1), .illegal_o(il1),
    .stall_cnt_o(sc1)
  );

  decode_ctrl_pipe #(.STALL_CYCLES(2), .PERF_W(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr), .valid_i(valid), .flush_i(flush),
    .stall_o(s2), .valid_o(v2), .RegWrite_o(rw2), .ALUSrc_o(as2), .ALUSigned_o(sg2),
    .Branch_o(br2), .Jump_o(j2), .MemRead_o(mr2), .MemWrite_o(mw2), .ALU_op_o(aop2),
    .RegDst_o(rd2), .BranchType_o(bt2), .MemToReg_o(mtr2), .illegal_o(il2),
    .stall_cnt_o(sc2)
  );

  assign vec1 = {v1, rw1, as1, sg1, br1, j1, mr1, mw1, aop1, rd1, bt1, mtr1, il1};
  assign vec2 = {v2, rw2, as2, sg2, br2, j2, mr2, mw2, aop2, rd2, bt2, mtr2, il2};

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt);
    return {op, rs, rt, 16'h0};
  endfunction

  function automatic logic [17:0] pk(input logic v, input logic rw, input logic as,
                                     input logic sg, input logic br, input logic j,
                                     input logic mr, input logic mw, input logic [2:0] aop,
                                     input logic [1:0] rd, input logic [1:0] bt,
                                     input logic [1:0] mtr, input logic il);
    return {v, rw, as, sg, br, j, mr, mw, aop, rd, bt, mtr, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive after the falling edge; registered outputs still show the previous decode.
  task automatic set(input logic [31:0] i, input logic v, input logic f);
    @(negedge clk);
    instr = i;
    valid = v;
    flush = f;
    #1;
  endtask

  logic [5:0]  ops [14];
  logic [17:0] ex  [14];
  logic [17:0] r_vec, lw_vec, sw_vec;

  initial begin
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd13, 6'd15, 6'd35,
            6'd43, 6'd7};
    ex[0]  = pk(1, 1, 0, 1, 0, 0, 0, 0, 3'b010, 2'd1, 2'd0, 2'd0, 0);
    ex[1]  = pk(1, 0, 0, 1, 1, 0, 0, 0, 3'b001, 2'd0, 2'd3, 2'd0, 0);
    ex[2]  = pk(1, 0, 0, 1, 0, 1, 0, 0, 3'b000, 2'd0, 2'd0, 2'd0, 0);
    ex[3]  = pk(1, 1, 0, 1, 0, 1, 0, 0, 3'b000, 2'd2, 2'd0, 2'd2, 0);
    ex[4]  = pk(1, 0, 0, 1, 1, 0, 0, 0, 3'b001, 2'd0, 2'd0, 2'd0, 0);
    ex[5]  = pk(1, 0, 0, 1, 1, 0, 0, 0, 3'b001, 2'd0, 2'd1, 2'd0, 0);
    ex[6]  = pk(1, 0, 0, 1, 1, 0, 0, 0, 3'b001, 2'd0, 2'd2, 2'd0, 0);
    ex[7]  = pk(1, 1, 1, 1, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 2'd0, 0);
    ex[8]  = pk(1, 1, 1, 0, 0, 0, 0, 0, 3'b011, 2'd0, 2'd0, 2'd0, 0);
    ex[9]  = pk(1, 1, 1, 0, 0, 0, 0, 0, 3'b100, 2'd0, 2'd0, 2'd0, 0);
    ex[10] = pk(1, 1, 1, 1, 0, 0, 0, 0, 3'b101, 2'd0, 2'd0, 2'd0, 0);
    ex[11] = pk(1, 1, 1, 1, 0, 0, 1, 0, 3'b000, 2'd0, 2'd0, 2'd1, 0);
    ex[12] = pk(1, 0, 1, 1, 0, 0, 0, 1, 3'b000, 2'd0, 2'd0, 2'd0, 0);
    ex[13] = pk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 2'd0, 1);
    r_vec  = ex[0];
    lw_vec = ex[11];
    sw_vec = ex[12];

    // Power-on reset
    #1;
    chk("reset_vec1", 32'(vec1), 32'h0);
    chk("reset_vec2", 32'(vec2), 32'h0);
    chk("reset_stall1", 32'(s1), 32'h0);
    chk("reset_stall_cnt2", 32'(sc2), 32'h0);
    @(negedge clk);
    rst_i = 1'b1;

    // Decode sweep; rs=rt=0 so no hazard can fire
    for (int k = 0; k < 14; k++) begin
      set(ins(ops[k], 5'd0, 5'd0), 1'b1, 1'b0);
      if (k > 0) begin
        chk($sformatf("dec1_op%0d", ops[k-1]), 32'(vec1), 32'(ex[k-1]));
        chk($sformatf("dec2_op%0d", ops[k-1]), 32'(vec2), 32'(ex[k-1]));
      end
    end
    set(32'h0, 1'b0, 1'b0);
    chk("dec1_op7_illegal", 32'(vec1), 32'(ex[13]));
    set(32'h0, 1'b0, 1'b0);
    chk("illegal_pulse_clear", 32'(vec1), 32'h0);
    chk("sweep_no_stall_cnt", 32'(sc1), 32'h0);

    // One-bubble stall: lw $5 ; add $6,$5,$1
    set(ins(6'd35, 5'd0, 5'd5), 1'b1, 1'b0);
    chk("s1_lw_no_stall", 32'(s1), 32'h0);
    set(ins(6'd0, 5'd5, 5'd1), 1'b1, 1'b0);
    chk("s1_hazard_stall", 32'(s1), 32'h1);
    chk("s1_lw_decoded", 32'(vec1), 32'(lw_vec));
    set(ins(6'd0, 5'd5, 5'd1), 1'b1, 1'b0);
    chk("s1_stall_done", 32'(s1), 32'h0);
    chk("s1_bubble", 32'(vec1), 32'h0);
    chk("s1_stall_cnt", 32'(sc1), 32'h1);
    set(32'h0, 1'b0, 1'b0);
    chk("s1_add_decoded", 32'(vec1), 32'(r_vec));

    // Asynchronous reset between edges
    #2;
    rst_i = 1'b0;
    #1;
    chk("midreset_vec1", 32'(vec1), 32'h0);
    chk("midreset_stall_cnt1", 32'(sc1), 32'h0);
    chk("midreset_stall_cnt2", 32'(sc2), 32'h0);
    @(negedge clk);
    rst_i = 1'b1;

    // Two-bubble stall on rt use: lw $5 ; sw $5
    set(ins(6'd35, 5'd0, 5'd5), 1'b1, 1'b0);
    chk("s2_lw_no_stall", 32'(s2), 32'h0);
    set(ins(6'd43, 5'd0, 5'd5), 1'b1, 1'b0);
    chk("s2_hazard_stall", 32'(s2), 32'h1);
    chk("s2_lw_decoded", 32'(vec2), 32'(lw_vec));
    set(ins(6'd43, 5'd0, 5'd5), 1'b1, 1'b0);
    chk("s2_second_stall", 32'(s2), 32'h1);
    chk("s2_bubble1", 32'(vec2), 32'h0);
    chk("s2_stall_cnt_1", 32'(sc2), 32'h1);
    set(ins(6'd43, 5'd0, 5'd5), 1'b1, 1'b0);
    chk("s2_stall_done", 32'(s2), 32'h0);
    chk("s2_bubble2", 32'(vec2), 32'h0);
    chk("s2_stall_cnt_2", 32'(sc2), 32'h2);
    set(32'h0, 1'b0, 1'b0);
    chk("s2_sw_decoded", 32'(vec2), 32'(sw_vec));
    chk("s2_stall_cnt_hold", 32'(sc2), 32'h2);

    // No hazard: $0 destination, and rt of addi is not a source
    set(ins(6'd35, 5'd0, 5'd0), 1'b1, 1'b0);
    set(ins(6'd0, 5'd0, 5'd0), 1'b1, 1'b0);
    chk("nohaz_r0_stall2", 32'(s2), 32'h0);
    chk("nohaz_r0_stall1", 32'(s1), 32'h0);
    set(ins(6'd35, 5'd0, 5'd5), 1'b1, 1'b0);
    set(ins(6'd8, 5'd1, 5'd5), 1'b1, 1'b0);
    chk("nohaz_addi_rt_stall2", 32'(s2), 32'h0);
    chk("nohaz_lw_decoded", 32'(vec2), 32'(lw_vec));

    // Flush in the first of two stall cycles
    set(ins(6'd35, 5'd0, 5'd5), 1'b1, 1'b0);
    set(ins(6'd0, 5'd5, 5'd1), 1'b1, 1'b1);
    chk("flush_stall_reported", 32'(s2), 32'h1);
    set(ins(6'd0, 5'd5, 5'd1), 1'b1, 1'b0);
    chk("flush_stall_ended", 32'(s2), 32'h0);
    chk("flush_bubble", 32'(vec2), 32'h0);
    chk("flush_stall_cnt", 32'(sc2), 32'h2);
    set(32'h0, 1'b0, 1'b0);
    chk("flush_add_decoded", 32'(vec2), 32'(r_vec));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
